// File: rtl/wavecap_pkg.sv
// Shared types for the ping-pong waveform capture buffer: FSM state encoding
// and trigger-mode codes.
package wavecap_pkg;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_WAIT_TRIG,
    ST_CAPTURE,
    ST_DONE,
    ST_HOLD
  } state_e;

  typedef enum logic [1:0] {
    TRIG_FREE = 2'b00,
    TRIG_RISE = 2'b01,
    TRIG_FALL = 2'b10,
    TRIG_BOTH = 2'b11
  } trig_mode_e;

endpackage

// File: rtl/wavecap_trig_detect.sv
// Level-crossing detector: remembers the previous accepted sample and flags a
// one-cycle trig_hit_o when the current accepted sample satisfies the mode.
module wavecap_trig_detect
  import wavecap_pkg::*;
#(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          valid_i,
  input  logic [DW-1:0] sample_i,
  input  logic [DW-1:0] level_i,
  input  trig_mode_e    mode_i,
  output logic          trig_hit_o
);

  logic [DW-1:0] prev_q;
  logic          prev_valid_q;
  logic          rise;
  logic          fall;

  assign rise = prev_valid_q && (prev_q <  level_i) && (sample_i >= level_i);
  assign fall = prev_valid_q && (prev_q >= level_i) && (sample_i <  level_i);

  always_comb begin
    trig_hit_o = 1'b0;
    if (valid_i) begin
      case (mode_i)
        TRIG_FREE: trig_hit_o = 1'b1;
        TRIG_RISE: trig_hit_o = rise;
        TRIG_FALL: trig_hit_o = fall;
        TRIG_BOTH: trig_hit_o = rise || fall;
        default:   trig_hit_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (clear_i) begin
      prev_valid_q <= 1'b0;
    end else if (valid_i) begin
      prev_q       <= sample_i;
      prev_valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/wave_capture_buffer.sv
// NCH-channel ping-pong capture buffer with decimation, edge triggering and
// frame-synchronous bank swap. Optional auto-trigger: WAVECAP_AUTOTRIG_EN.
module wave_capture_buffer
  import wavecap_pkg::*;
#(
  parameter  int NCH     = 2,
  parameter  int DW      = 10,
  parameter  int DEPTH   = 640,
  parameter  int AW      = 10,
  parameter  int DECIM_W = 8,
  parameter  int AUTO_TO = 4096,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [DECIM_W-1:0] decim,
  input  logic [1:0]        trig_mode,
  input  logic [CW-1:0]     trig_ch,
  input  logic [DW-1:0]     trig_level,
  input  logic              frame_start,
  input  logic              freeze,
  input  logic [AW-1:0]     rd_addr,
  output logic [NCH*DW-1:0] rd_data,
  output logic              disp_valid,
  output logic              capturing,
  output logic [15:0]       frame_cnt
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic                wr_bank_q, wr_bank_d;
  logic                disp_valid_q, disp_valid_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [DECIM_W-1:0]  decim_q, decim_d;
  logic [DECIM_W-1:0]  dcnt_q, dcnt_d;
  trig_mode_e          mode_q, mode_d;
  logic [CW-1:0]       tch_q, tch_d;
  logic [DW-1:0]       level_q, level_d;

  logic                accept;
  logic                trig_valid;
  logic                trig_clear;
  logic                trig_hit;
  logic                force_trig;
  logic                wr_en;
  logic [DW-1:0]       trig_sample;
  logic                rd_in_range;

  assign accept      = sample_tick && (dcnt_q == '0);
  assign trig_valid  = accept && (state_q == ST_WAIT_TRIG);
  assign trig_clear  = (state_q == ST_ARM);
  assign rd_in_range = ({1'b0, rd_addr} < (AW+1)'(DEPTH));

  always_comb begin
    trig_sample = '0;
    for (int i = 0; i < NCH; i++) begin
      if (tch_q == CW'(i)) trig_sample = ch_data[i*DW +: DW];
    end
  end

  wavecap_trig_detect #(.DW(DW)) u_trig (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (trig_clear),
    .valid_i    (trig_valid),
    .sample_i   (trig_sample),
    .level_i    (level_q),
    .mode_i     (mode_q),
    .trig_hit_o (trig_hit)
  );

`ifdef WAVECAP_AUTOTRIG_EN
  localparam int TOW = $clog2(AUTO_TO + 1);
  logic [TOW-1:0] to_cnt_q;

  // Counts untriggered accepted samples in edge modes; the AUTO_TO-th one forces capture.
  assign force_trig = trig_valid && (mode_q != TRIG_FREE) && (to_cnt_q == TOW'(AUTO_TO - 1));

  always_ff @(posedge clk) begin
    if (reset || state_q == ST_ARM) to_cnt_q <= '0;
    else if (trig_valid && mode_q != TRIG_FREE && !trig_hit) to_cnt_q <= to_cnt_q + TOW'(1);
  end
`else
  logic unused_auto_to;
  assign unused_auto_to = (AUTO_TO != 0);
  assign force_trig     = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_bank_d    = wr_bank_q;
    disp_valid_d = disp_valid_q;
    frame_cnt_d  = frame_cnt_q;
    decim_d      = decim_q;
    mode_d       = mode_q;
    tch_d        = tch_q;
    level_d      = level_q;
    dcnt_d       = dcnt_q;
    wr_en        = 1'b0;

    if (sample_tick) dcnt_d = (dcnt_q == '0) ? decim_q : dcnt_q - 1'b1;

    case (state_q)
      ST_ARM: begin
        decim_d  = decim;
        mode_d   = trig_mode_e'(trig_mode);
        tch_d    = trig_ch;
        level_d  = trig_level;
        wr_ptr_d = '0;
        state_d  = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG, ST_CAPTURE: begin
        // The triggering sample itself lands at address 0 (wr_ptr is still clear).
        if ((state_q == ST_CAPTURE && accept) || trig_hit || force_trig) begin
          wr_en = 1'b1;
          if (wr_ptr_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            state_d  = ST_CAPTURE;
          end
        end
      end
      ST_DONE: begin
        if (frame_start) begin
          wr_bank_d    = ~wr_bank_q;
          disp_valid_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          state_d      = freeze ? ST_HOLD : ST_ARM;
        end
      end
      ST_HOLD: begin
        if (!freeze) state_d = ST_ARM;
      end
      default: state_d = ST_ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ARM;
      wr_ptr_q     <= '0;
      wr_bank_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      frame_cnt_q  <= '0;
      decim_q      <= '0;
      dcnt_q       <= '0;
      mode_q       <= TRIG_FREE;
      tch_q        <= '0;
      level_q      <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_bank_q    <= wr_bank_d;
      disp_valid_q <= disp_valid_d;
      frame_cnt_q  <= frame_cnt_d;
      decim_q      <= decim_d;
      dcnt_q       <= dcnt_d;
      mode_q       <= mode_d;
      tch_q        <= tch_d;
      level_q      <= level_d;
    end
  end

  // Display bank is always the complement of the write bank, so reads never alias writes.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (wr_en && !wr_bank_q) mem0[wr_ptr_q] <= ch_data[c*DW +: DW];
      if (wr_en &&  wr_bank_q) mem1[wr_ptr_q] <= ch_data[c*DW +: DW];
    end

    always_ff @(posedge clk) begin
      if (reset || !rd_in_range) rd_q <= '0;
      else if (wr_bank_q)        rd_q <= mem0[rd_addr];
      else                       rd_q <= mem1[rd_addr];
    end

    assign rd_data[c*DW +: DW] = rd_q;
  end

  assign disp_valid = disp_valid_q;
  assign capturing  = (state_q == ST_CAPTURE);
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Directed self-checking bench for wave_capture_buffer (NCH=2, DW=10, DEPTH=640).
// The auto-trigger scenario follows WAVECAP_AUTOTRIG_EN when it is defined.
module tb_wave_capture_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_tick = 1'b0;
  logic [19:0] ch_data = '0;
  logic [7:0]  decim = '0;
  logic [1:0]  trig_mode = 2'b00;
  logic [0:0]  trig_ch = 1'b0;
  logic [9:0]  trig_level = '0;
  logic        frame_start = 1'b0;
  logic        freeze = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [19:0] rd_data;
  logic        disp_valid;
  logic        capturing;
  logic [15:0] frame_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  wave_capture_buffer #(
    .NCH(2), .DW(10), .DEPTH(640), .AW(10), .DECIM_W(8), .AUTO_TO(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .ch_data     (ch_data),
    .decim       (decim),
    .trig_mode   (trig_mode),
    .trig_ch     (trig_ch),
    .trig_level  (trig_level),
    .frame_start (frame_start),
    .freeze      (freeze),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .disp_valid  (disp_valid),
    .capturing   (capturing),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input logic [1:0] mode, input logic [7:0] dec, input logic [9:0] lvl);
    trig_mode = mode; decim = dec; trig_level = lvl; trig_ch = 1'b0;
    freeze = 1'b0; frame_start = 1'b0; sample_tick = 1'b0; rd_addr = '0;
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(2);
  endtask

  task automatic send_sample(input logic [9:0] a, input logic [9:0] b, input logic fs);
    ch_data = {b, a}; sample_tick = 1'b1; frame_start = fs;
    cycles(1);
    sample_tick = 1'b0; frame_start = 1'b0;
    cycles(1);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    cycles(1);
    frame_start = 1'b0;
    cycles(1);
  endtask

  task automatic read_addr(input logic [9:0] a, output logic [19:0] d);
    rd_addr = a;
    cycles(1);
    d = rd_data;
  endtask

  task automatic capture_ramp();
    for (int n = 0; n < 640; n++) send_sample(10'(n), 10'(1023 - n), 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; rd_addr = '0;
    cycles(2);
    n_cmp++; if (disp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_disp_valid: got %b want 0", disp_valid); end
    n_cmp++; if (capturing !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_capturing: got %b want 0", capturing); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    n_cmp++; if (rd_data !== 20'd0) begin n_fail++; $display("[TB] FAIL reset_rd_data: got %h want 0", rd_data); end
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    logic [19:0] d;
    do_reset(2'b00, 8'd0, 10'd0);
    send_sample(10'd0, 10'd1023, 1'b0);
    n_cmp++; if (capturing !== 1'b1) begin n_fail++; $display("[TB] FAIL free_capturing_start: got %b want 1", capturing); end
    for (int n = 1; n < 640; n++) send_sample(10'(n), 10'(1023 - n), 1'b0);
    n_cmp++; if (capturing !== 1'b0) begin n_fail++; $display("[TB] FAIL free_capturing_done: got %b want 0", capturing); end
    n_cmp++; if (disp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL free_valid_before_swap: got %b want 0", disp_valid); end
    pulse_frame();
    n_cmp++; if (disp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL free_disp_valid: got %b want 1", disp_valid); end
    n_cmp++; if (frame_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL free_frame_cnt: got %0d want 1", frame_cnt); end
    read_addr(10'd5, d);
    n_cmp++; if (d !== {10'd1018, 10'd5}) begin n_fail++; $display("[TB] FAIL free_addr5: got %h want %h", d, {10'd1018, 10'd5}); end
    read_addr(10'd639, d);
    n_cmp++; if (d !== {10'd384, 10'd639}) begin n_fail++; $display("[TB] FAIL free_addr639: got %h want %h", d, {10'd384, 10'd639}); end
    read_addr(10'd640, d);
    n_cmp++; if (d !== 20'd0) begin n_fail++; $display("[TB] FAIL free_addr640: got %h want 0", d); end
  endtask

  task automatic test_trig_edges();
    logic [19:0] d;
    // Rising: 600 (no predecessor), 100 (falling edge, ignored), 511, then 512 triggers.
    do_reset(2'b01, 8'd0, 10'd512);
    send_sample(10'd600, 10'd1, 1'b0);
    send_sample(10'd100, 10'd2, 1'b0);
    send_sample(10'd511, 10'd3, 1'b0);
    n_cmp++; if (capturing !== 1'b0) begin n_fail++; $display("[TB] FAIL rise_no_early_trig: got %b want 0", capturing); end
    send_sample(10'd512, 10'd42, 1'b0);
    n_cmp++; if (capturing !== 1'b1) begin n_fail++; $display("[TB] FAIL rise_trig: got %b want 1", capturing); end
    for (int i = 1; i < 640; i++) send_sample(10'(i), 10'(1023 - i), 1'b0);
    pulse_frame();
    read_addr(10'd0, d);
    n_cmp++; if (d !== {10'd42, 10'd512}) begin n_fail++; $display("[TB] FAIL rise_addr0: got %h want %h", d, {10'd42, 10'd512}); end
    read_addr(10'd1, d);
    n_cmp++; if (d !== {10'd1022, 10'd1}) begin n_fail++; $display("[TB] FAIL rise_addr1: got %h want %h", d, {10'd1022, 10'd1}); end
    // Falling: 100 (no predecessor), 700 (rising, ignored), 512 (not below), then 511 triggers.
    do_reset(2'b10, 8'd0, 10'd512);
    send_sample(10'd100, 10'd1, 1'b0);
    send_sample(10'd700, 10'd2, 1'b0);
    send_sample(10'd512, 10'd3, 1'b0);
    n_cmp++; if (capturing !== 1'b0) begin n_fail++; $display("[TB] FAIL fall_no_early_trig: got %b want 0", capturing); end
    send_sample(10'd511, 10'd42, 1'b0);
    n_cmp++; if (capturing !== 1'b1) begin n_fail++; $display("[TB] FAIL fall_trig: got %b want 1", capturing); end
    for (int i = 1; i < 640; i++) send_sample(10'(i), 10'(1023 - i), 1'b0);
    pulse_frame();
    read_addr(10'd0, d);
    n_cmp++; if (d !== {10'd42, 10'd511}) begin n_fail++; $display("[TB] FAIL fall_addr0: got %h want %h", d, {10'd42, 10'd511}); end
  endtask

  task automatic test_decimation();
    logic [19:0] d;
    do_reset(2'b00, 8'd3, 10'd0);
    for (int t = 0; t < 2560; t++) begin
      send_sample(10'(t), 10'd0, 1'b0);
      if (t == 2555) begin
        n_cmp++; if (capturing !== 1'b1) begin n_fail++; $display("[TB] FAIL decim_still_capturing: got %b want 1", capturing); end
      end
      if (t == 2556) begin
        n_cmp++; if (capturing !== 1'b0) begin n_fail++; $display("[TB] FAIL decim_done: got %b want 0", capturing); end
      end
    end
    pulse_frame();
    read_addr(10'd1, d);
    n_cmp++; if (d !== {10'd0, 10'd4}) begin n_fail++; $display("[TB] FAIL decim_addr1: got %h want %h", d, {10'd0, 10'd4}); end
    read_addr(10'd2, d);
    n_cmp++; if (d !== {10'd0, 10'd8}) begin n_fail++; $display("[TB] FAIL decim_addr2: got %h want %h", d, {10'd0, 10'd8}); end
    read_addr(10'd256, d);
    n_cmp++; if (d !== 20'd0) begin n_fail++; $display("[TB] FAIL decim_addr256: got %h want 0", d); end
    read_addr(10'd639, d);
    n_cmp++; if (d !== {10'd0, 10'd508}) begin n_fail++; $display("[TB] FAIL decim_addr639: got %h want %h", d, {10'd0, 10'd508}); end
  endtask

  task automatic test_frame_during_capture();
    logic [19:0] d;
    do_reset(2'b00, 8'd0, 10'd0);
    for (int n = 0; n < 10; n++) send_sample(10'(n), 10'(n), 1'b0);
    pulse_frame();
    n_cmp++; if (frame_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL midcap_frame_cnt: got %0d want 0", frame_cnt); end
    n_cmp++; if (capturing !== 1'b1) begin n_fail++; $display("[TB] FAIL midcap_capturing: got %b want 1", capturing); end
    for (int n = 10; n < 639; n++) send_sample(10'(n), 10'(n), 1'b0);
    send_sample(10'd639, 10'd639, 1'b1);
    n_cmp++; if (frame_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL lastwrite_frame_cnt: got %0d want 0", frame_cnt); end
    n_cmp++; if (disp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL lastwrite_disp_valid: got %b want 0", disp_valid); end
    pulse_frame();
    n_cmp++; if (frame_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL after_done_frame_cnt: got %0d want 1", frame_cnt); end
    read_addr(10'd639, d);
    n_cmp++; if (d !== {10'd639, 10'd639}) begin n_fail++; $display("[TB] FAIL after_done_addr639: got %h want %h", d, {10'd639, 10'd639}); end
  endtask

  task automatic test_freeze();
    logic [19:0] d;
    do_reset(2'b00, 8'd0, 10'd0);
    capture_ramp();
    freeze = 1'b1;
    pulse_frame();
    pulse_frame();
    pulse_frame();
    n_cmp++; if (frame_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL freeze_frame_cnt: got %0d want 1", frame_cnt); end
    for (int n = 0; n < 640; n++) send_sample(10'(n + 3), 10'(n + 3), 1'b0);
    n_cmp++; if (capturing !== 1'b0) begin n_fail++; $display("[TB] FAIL freeze_no_capture: got %b want 0", capturing); end
    read_addr(10'd5, d);
    n_cmp++; if (d !== {10'd1018, 10'd5}) begin n_fail++; $display("[TB] FAIL freeze_addr5: got %h want %h", d, {10'd1018, 10'd5}); end
    freeze = 1'b0;
    cycles(2);
    send_sample(10'd77, 10'd77, 1'b0);
    n_cmp++; if (capturing !== 1'b1) begin n_fail++; $display("[TB] FAIL unfreeze_capture: got %b want 1", capturing); end
    read_addr(10'd5, d);
    n_cmp++; if (d !== {10'd1018, 10'd5}) begin n_fail++; $display("[TB] FAIL unfreeze_addr5: got %h want %h", d, {10'd1018, 10'd5}); end
  endtask

  task automatic test_auto_trigger();
    do_reset(2'b01, 8'd0, 10'd512);
`ifdef WAVECAP_AUTOTRIG_EN
    for (int i = 0; i < 15; i++) send_sample(10'd100, 10'd0, 1'b0);
    n_cmp++; if (capturing !== 1'b0) begin n_fail++; $display("[TB] FAIL auto_before_timeout: got %b want 0", capturing); end
    send_sample(10'd100, 10'd0, 1'b0);
    n_cmp++; if (capturing !== 1'b1) begin n_fail++; $display("[TB] FAIL auto_timeout: got %b want 1", capturing); end
`else
    for (int i = 0; i < 10000; i++) send_sample(10'd100, 10'd0, 1'b0);
    n_cmp++; if (capturing !== 1'b0) begin n_fail++; $display("[TB] FAIL noauto_capturing: got %b want 0", capturing); end
    n_cmp++; if (disp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL noauto_disp_valid: got %b want 0", disp_valid); end
`endif
  endtask

  task automatic test_reset_mid_capture();
    do_reset(2'b00, 8'd0, 10'd0);
    capture_ramp();
    pulse_frame();
    n_cmp++; if (disp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rmc_valid_before: got %b want 1", disp_valid); end
    for (int n = 0; n < 5; n++) send_sample(10'(n), 10'(n), 1'b0);
    n_cmp++; if (capturing !== 1'b1) begin n_fail++; $display("[TB] FAIL rmc_capturing_before: got %b want 1", capturing); end
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    n_cmp++; if (disp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rmc_disp_valid: got %b want 0", disp_valid); end
    n_cmp++; if (capturing !== 1'b0) begin n_fail++; $display("[TB] FAIL rmc_capturing: got %b want 0", capturing); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL rmc_frame_cnt: got %0d want 0", frame_cnt); end
    cycles(2);
    send_sample(10'd9, 10'd9, 1'b0);
    n_cmp++; if (capturing !== 1'b1) begin n_fail++; $display("[TB] FAIL rmc_rearm: got %b want 1", capturing); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_trig_edges();
    test_decimation();
    test_frame_during_capture();
    test_freeze();
    test_auto_trigger();
    test_reset_mid_capture();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
